// File: rtl/otdr_defs.sv
// Shared definitions for the OTDR shot sequencer: state encoding, parameter defaults
// and the holdoff reload helper.
package otdr_defs;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArm     = 3'd1,
        StFire    = 3'd2,
        StAcq     = 3'd3,
        StHoldoff = 3'd4,
        StFinish  = 3'd5
    } seq_state_e;

    localparam int unsigned TrigLenDefault    = 2;
    localparam int unsigned AcqTimeoutDefault = 65535;

    // A zero holdoff still spends one cycle in HOLDOFF, so it reloads like a holdoff of 1.
    function automatic logic [15:0] holdoff_load(input logic [15:0] holdoff);
        return (holdoff == 16'd0) ? 16'd0 : holdoff - 16'd1;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// 16-bit loadable down-counter with a zero flag; shared by FIRE length, ACQ timeout
// and HOLDOFF dead time.
module seq_timer (
    input  logic        clock,
    input  logic        reset_async,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        zero
);

    logic [15:0] count;

    always_ff @(posedge clock or negedge reset_async) begin
        if (!reset_async) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/otdr_shot_seq.sv
// OTDR shot sequencer: arms, fires and acquires a configurable number of shots with
// dead time between them; every output is a registered function of the next state.
module otdr_shot_seq
    import otdr_defs::*;
#(
    parameter int unsigned TRIG_LEN    = TrigLenDefault,
    parameter int unsigned ACQ_TIMEOUT = AcqTimeoutDefault
) (
    input  logic        clock,
    input  logic        reset_async,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  cfg_pulse_width,
    input  logic [7:0]  cfg_pulse_n,
    input  logic [15:0] cfg_shots,
    input  logic [15:0] cfg_holdoff,
    input  logic        acq_done,
    output logic [7:0]  pulse_width,
    output logic [7:0]  pulse_n,
    output logic        pulse_trigger,
    output logic        acq_busy,
    output logic        acq_start,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [15:0] shot_count
);

    localparam logic [15:0] TrigLoad = 16'(TRIG_LEN - 1);
    localparam logic [15:0] AcqLoad  = 16'(ACQ_TIMEOUT - 1);

    seq_state_e  state;
    logic [15:0] sh_shots;
    logic [15:0] sh_holdoff;
    logic [15:0] count_inc;
    logic        last_shot;

    logic        t_load;
    logic [15:0] t_val;
    logic        t_en;
    logic        t_zero;

    assign count_inc = shot_count + 16'd1;
    assign last_shot = (count_inc == sh_shots);

    seq_timer u_timer (
        .clock       (clock),
        .reset_async (reset_async),
        .load        (t_load),
        .load_val    (t_val),
        .en          (t_en),
        .zero        (t_zero)
    );

    // Timer is reloaded on entry to each timed state so stale counts never leak across.
    always_comb begin
        t_load = 1'b0;
        t_val  = 16'd0;
        t_en   = 1'b0;
        unique case (state)
            StArm: begin
                if (!abort) begin
                    t_load = 1'b1;
                    t_val  = TrigLoad;
                end
            end
            StFire: begin
                if (!abort && t_zero) begin
                    t_load = 1'b1;
                    t_val  = AcqLoad;
                end else begin
                    t_en = 1'b1;
                end
            end
            StAcq: begin
                if (!abort && acq_done && !last_shot) begin
                    t_load = 1'b1;
                    t_val  = holdoff_load(sh_holdoff);
                end else begin
                    t_en = 1'b1;
                end
            end
            StHoldoff: t_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_async) begin
        if (!reset_async) begin
            state         <= StIdle;
            sh_shots      <= 16'd0;
            sh_holdoff    <= 16'd0;
            pulse_width   <= 8'd0;
            pulse_n       <= 8'd0;
            pulse_trigger <= 1'b0;
            acq_busy      <= 1'b0;
            acq_start     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            shot_count    <= 16'd0;
        end else begin
            acq_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        pulse_width <= cfg_pulse_width;
                        pulse_n     <= cfg_pulse_n;
                        sh_shots    <= cfg_shots;
                        sh_holdoff  <= cfg_holdoff;
                        shot_count  <= 16'd0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        if (cfg_shots == 16'd0) begin
                            state <= StFinish;
                            done  <= 1'b1;
                        end else begin
                            state <= StArm;
                        end
                    end
                end
                StArm: begin
                    if (abort) begin
                        state <= StFinish;
                        done  <= 1'b1;
                    end else begin
                        state         <= StFire;
                        pulse_trigger <= 1'b1;
                        acq_start     <= 1'b1;
                        acq_busy      <= 1'b1;
                    end
                end
                StFire: begin
                    if (abort) begin
                        state         <= StFinish;
                        done          <= 1'b1;
                        pulse_trigger <= 1'b0;
                        acq_busy      <= 1'b0;
                    end else if (t_zero) begin
                        state         <= StAcq;
                        pulse_trigger <= 1'b0;
                    end
                end
                StAcq: begin
                    // Abort beats a coincident acq_done; acq_done beats a coincident timeout.
                    if (abort) begin
                        state    <= StFinish;
                        done     <= 1'b1;
                        acq_busy <= 1'b0;
                    end else if (acq_done) begin
                        shot_count <= count_inc;
                        acq_busy   <= 1'b0;
                        if (last_shot) begin
                            state <= StFinish;
                            done  <= 1'b1;
                        end else begin
                            state <= StHoldoff;
                        end
                    end else if (t_zero) begin
                        state       <= StFinish;
                        done        <= 1'b1;
                        acq_busy    <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                StHoldoff: begin
                    if (abort) begin
                        state <= StFinish;
                        done  <= 1'b1;
                    end else if (t_zero) begin
                        state <= StArm;
                    end
                end
                StFinish: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state         <= StIdle;
                    busy          <= 1'b0;
                    pulse_trigger <= 1'b0;
                    acq_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
